// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StDone
  } state_e;

  typedef enum logic {
    OpLd = 1'b0,
    OpSt = 1'b1
  } op_e;

  localparam int unsigned WaitCycMin = 1;
  localparam int unsigned WaitCycMax = 15;

  function automatic bit wait_cyc_ok(input int unsigned wait_cyc);
    return (wait_cyc >= WaitCycMin) && (wait_cyc <= WaitCycMax);
  endfunction

endpackage

// File: rtl/dmem_sp_ram.sv
// Single-port synchronous RAM: registered read, write on rising edge when we is high.
module dmem_sp_ram #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data RAM responder: one word load/store per request with a fixed wait-state latency,
// stalling the core via Busy until the access completes.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RAMRead,
  input  logic              RAMWrite,
  input  logic [31:0]       Addr,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData,
  output logic              Busy,
  output logic              Done,
  output logic              Err
);

  if (!wait_cyc_ok(WAIT_CYC)) begin : gen_wait_cyc_bad
    $error("data_mem_responder: WAIT_CYC out of range 1..15");
  end

  localparam logic [3:0] CntLoad = 4'(WAIT_CYC - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  op_e               op_q, op_d;
  logic              mis_q, mis_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              req;
  logic              misaligned;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rdata;
  logic              unused_addr;

  assign req         = RAMRead | RAMWrite;
  assign misaligned  = (Addr[1:0] != 2'b00);
  assign unused_addr = ^Addr[31:ADDR_W+2];

  // Present the live address in IDLE so the registered read is already valid in WAIT.
  assign ram_addr = (state_q == StIdle) ? Addr[ADDR_W+1:2] : addr_q;

  dmem_sp_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(wdata_q),
    .rdata(ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    op_d    = op_q;
    mis_d   = mis_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    ram_we  = 1'b0;
    Busy    = 1'b0;
    Done    = 1'b0;
    Err     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req) begin
          Busy    = 1'b1;
          state_d = StWait;
          cnt_d   = CntLoad;
          addr_d  = Addr[ADDR_W+1:2];
          wdata_d = WriteData;
          op_d    = RAMWrite ? OpSt : OpLd;
          mis_d   = misaligned;
          err_d   = misaligned | (RAMRead & RAMWrite);
        end
      end
      StWait: begin
        Busy = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = StDone;
          if (!mis_q) begin
            if (op_q == OpSt) begin
              ram_we = 1'b1;
            end else begin
              rdata_d = ram_rdata;
            end
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone: begin
        // Strobes still belong to the finished instruction, so they are not sampled here.
        Done    = 1'b1;
        Err     = err_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      op_q    <= OpLd;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      op_q    <= op_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign ReadData = rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed scenarios plus random accesses against a word-array model.
module tb_data_mem_responder;

  localparam int unsigned ADDR_W   = 8;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned WAIT_CYC = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              RAMRead;
  logic              RAMWrite;
  logic [31:0]       Addr;
  logic [DATA_W-1:0] WriteData;
  logic [DATA_W-1:0] ReadData;
  logic              Busy;
  logic              Done;
  logic              Err;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] model_mem [int];
  logic [31:0] exp_rdata;
  bit          rdata_known;

  data_mem_responder #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .WAIT_CYC(WAIT_CYC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .RAMRead  (RAMRead),
    .RAMWrite (RAMWrite),
    .Addr     (Addr),
    .WriteData(WriteData),
    .ReadData (ReadData),
    .Busy     (Busy),
    .Done     (Done),
    .Err      (Err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete access; hold keeps the strobes high through WAIT and DONE, otherwise
  // junk strobes/address/data are driven after the request cycle.
  task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input bit hold);
    bit misal;
    bit err_exp;
    int idx;
    misal   = (a % 4) != 0;
    err_exp = misal || (rd && wr);
    idx     = int'((a / 4) % (1 << ADDR_W));
    if (wr) begin
      if (!misal) model_mem[idx] = wd;
    end else if (!misal) begin
      if (model_mem.exists(idx)) begin
        exp_rdata   = model_mem[idx];
        rdata_known = 1'b1;
      end else begin
        rdata_known = 1'b0;
      end
    end

    @(posedge clk); #1;
    RAMRead = rd; RAMWrite = wr; Addr = a; WriteData = wd;
    @(negedge clk);
    check("busy_req_cycle", Busy, 1);
    check("done_req_cycle", Done, 0);
    for (int c = 1; c <= int'(WAIT_CYC) + 1; c++) begin
      @(posedge clk); #1;
      if (!hold) begin
        RAMRead   = 1'($urandom_range(0, 1));
        RAMWrite  = 1'($urandom_range(0, 1));
        Addr      = $urandom;
        WriteData = $urandom;
      end
      @(negedge clk);
      if (c <= int'(WAIT_CYC)) begin
        check("busy_wait", Busy, 1);
        check("done_wait", Done, 0);
      end else begin
        check("busy_done", Busy, 0);
        check("done_pulse", Done, 1);
        check("err_done", Err, 32'(err_exp));
        if (rdata_known) check("readdata", ReadData, exp_rdata);
      end
    end
    @(posedge clk); #1;
    RAMRead = 1'b0; RAMWrite = 1'b0;
    @(negedge clk);
    check("no_second_access", Busy, 0);
    check("done_one_cycle", Done, 0);
  endtask

  initial begin
    rst = 1'b1; RAMRead = 1'b0; RAMWrite = 1'b0; Addr = '0; WriteData = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", Busy, 0);
    check("reset_done", Done, 0);
    check("reset_err", Err, 0);
    check("reset_readdata", ReadData, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_rdata = '0; rdata_known = 1'b1;

    access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b1);
    access(1'b1, 1'b0, 32'h10, 32'h0, 1'b1);
    check("store_load_value", ReadData, 32'hDEADBEEF);

    access(1'b0, 1'b1, 32'h13, 32'h12345678, 1'b0);
    access(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    check("misaligned_no_write", ReadData, 32'hDEADBEEF);

    access(1'b1, 1'b1, 32'h20, 32'h5, 1'b1);
    access(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
    check("conflict_write_wins", ReadData, 32'h5);

    access(1'b0, 1'b1, 32'h404, 32'hA5, 1'b0);
    access(1'b1, 1'b0, 32'h004, 32'h0, 1'b0);
    check("addr_wrap", ReadData, 32'hA5);

    access(1'b0, 1'b1, 32'h30, 32'h1, 1'b0);
    @(posedge clk); #1;
    RAMWrite = 1'b1; Addr = 32'h30; WriteData = 32'hBAD;
    @(posedge clk); #1;
    RAMWrite = 1'b0;
    @(negedge clk);
    check("busy_before_abort", Busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_no_done", Done, 0);
      check("abort_busy", Busy, 0);
      check("abort_readdata", ReadData, 0);
    end
    exp_rdata = '0; rdata_known = 1'b1;
    access(1'b1, 1'b0, 32'h30, 32'h0, 1'b0);
    check("abort_no_commit", ReadData, 32'h1);

    for (int n = 0; n < 60; n++) begin
      int unsigned r;
      logic [31:0] a;
      bit rd;
      bit wr;
      r  = $urandom_range(0, 7);
      rd = (r == 0) || (r >= 4);
      wr = (r <= 3);
      a  = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 15) << 2);
      if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
      access(rd, wr, a, $urandom, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
